// File: rtl/and16_serial_pkg.sv
// Shared constants and state encoding for the bit-serial AND block.
package and16_serial_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int CNT_W         = $clog2(WIDTH_DEFAULT);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/and16_serial_ntt_and.sv
// Single-bit AND primitive, shared by every bit position of the serial word.
module NTT_And (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a & b;

endmodule

// File: rtl/and16_serial.sv
// Bit-serial WIDTH-bit AND with a parallel result behind a valid/ready pair.
// Define AND16_SERIAL_MSB_FIRST_EN to fill the result from out[WIDTH-1] downward.
module and16_serial
    import and16_serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t             state;
    logic [CW-1:0]      count;
    logic [CW-1:0]      idx;
    logic [WIDTH-1:0]   word;
    logic               and_bit;
    logic               accept;

    NTT_And u_and (
        .a (a_bit),
        .b (b_bit),
        .y (and_bit)
    );

    // Handshake outputs depend only on registered state.
    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == HOLD);
    assign busy      = (state == COLLECT) && (count != '0);
    assign accept    = in_valid && in_ready;
    assign out       = word;

`ifdef AND16_SERIAL_MSB_FIRST_EN
    assign idx = LAST - count;
`else
    assign idx = count;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= COLLECT;
            count <= '0;
            word  <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        word[idx] <= and_bit;
                        if (count == LAST) begin
                            count <= '0;
                            state <= HOLD;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) state <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
